// File: rtl/key_expander.sv
// AES-128 key schedule writer: expands a cipher key into round keys 0..NROUNDS,
// producing one round key per clock and writing each into the round-key memory.
// The S-box is external and shared. This block drives the RotWord'ed word out on
// sub_in and receives the substituted word back on sub_out in the same cycle.
module key_expander #(
    parameter int ADDR_W  = 4,
    parameter int NROUNDS = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [127:0]      key_in,
    output logic [31:0]       sub_in,
    input  logic [31:0]       sub_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_add,
    output logic [127:0]      wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NROUNDS);

    state_t            state_reg, state_next;
    logic              wr_en_reg, wr_en_next;
    logic [ADDR_W-1:0] wr_add_reg, wr_add_next;
    logic [127:0]      wr_data_reg, wr_data_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [7:0]        rcon_reg, rcon_next;

    // The round-key register doubles as the write-data register: the key being
    // presented to memory is also the "previous" key for the next round.
    logic [31:0]  cur_w [4];
    logic [31:0]  nxt_w [4];
    logic [31:0]  t_word;
    logic [127:0] round_next;
    logic [7:0]   rcon_xtime;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_words
            assign cur_w[gi] = wr_data_reg[127-32*gi -: 32];
        end
    endgenerate

    assign sub_in = {cur_w[3][23:0], cur_w[3][31:24]};
    assign t_word = sub_out ^ {rcon_reg, 24'h0};

    // XOR chain: each new word depends on the new word before it.
    assign nxt_w[0] = cur_w[0] ^ t_word;
    generate
        for (gi = 1; gi < 4; gi++) begin : g_chain
            assign nxt_w[gi] = cur_w[gi] ^ nxt_w[gi-1];
        end
    endgenerate

    assign round_next = {nxt_w[0], nxt_w[1], nxt_w[2], nxt_w[3]};
    assign rcon_xtime = {rcon_reg[6:0], 1'b0} ^ (rcon_reg[7] ? 8'h1b : 8'h00);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and next-output logic; start is only looked at in IDLE.
    always_comb begin
        state_next   = state_reg;
        wr_en_next   = wr_en_reg;
        wr_add_next  = wr_add_reg;
        wr_data_next = wr_data_reg;
        busy_next    = busy_reg;
        done_next    = 1'b0;
        rcon_next    = rcon_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next   = EXPAND;
                    wr_en_next   = 1'b1;
                    wr_add_next  = '0;
                    wr_data_next = key_in;
                    busy_next    = 1'b1;
                    rcon_next    = 8'h01;
                end
            end
            EXPAND: begin
                if (wr_add_reg == LAST_ADDR) begin
                    // Last key has been presented; address and data hold.
                    state_next = FINISH;
                    wr_en_next = 1'b0;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    wr_add_next  = wr_add_reg + ADDR_W'(1);
                    wr_data_next = round_next;
                    rcon_next    = rcon_xtime;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_en_reg   <= 1'b0;
            wr_add_reg  <= '0;
            wr_data_reg <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            rcon_reg    <= 8'h01;
        end else begin
            wr_en_reg   <= wr_en_next;
            wr_add_reg  <= wr_add_next;
            wr_data_reg <= wr_data_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            rcon_reg    <= rcon_next;
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_add  = wr_add_reg;
    assign wr_data = wr_data_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule

// File: tb/tb_key_expander.sv
// Testbench for key_expander: supplies a computed AES S-box on the sub_in/sub_out
// loop and checks every write cycle against a FIPS-197 style word-by-word model.
module tb_key_expander;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic [127:0] key_in;
    logic [31:0]  sub_in;
    logic [31:0]  sub_out;
    logic         wr_en;
    logic [3:0]   wr_add;
    logic [127:0] wr_data;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_tab [256];
    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] exp_keys [11];

    // Per-cycle observations: index 0 is the cycle right after the start edge.
    logic         obs_en   [64];
    logic [3:0]   obs_add  [64];
    logic [127:0] obs_data [64];
    logic         obs_busy [64];
    logic         obs_done [64];

    key_expander #(.ADDR_W(4), .NROUNDS(10)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .key_in  (key_in),
        .sub_in  (sub_in),
        .sub_out (sub_out),
        .wr_en   (wr_en),
        .wr_add  (wr_add),
        .wr_data (wr_data),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    assign sub_out = {sbox_tab[sub_in[31:24]], sbox_tab[sub_in[23:16]],
                      sbox_tab[sub_in[15:8]],  sbox_tab[sub_in[7:0]]};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int v = 0; v < 256; v++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            logic [7:0] s;
            for (int u = 1; u < 256; u++) begin
                if (v != 0 && gmul(8'(v), 8'(u)) == 8'h01) inv = 8'(u);
            end
            b = inv;
            s = b ^ 8'h63;
            for (int r = 1; r <= 4; r++) begin
                b = {b[6:0], b[7]};
                s = s ^ b;
            end
            sbox_tab[v] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    // Textbook key expansion into 44 words, then grouped into 11 round keys.
    task automatic ref_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] tmp;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0)
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rcon_tab[i/4-1], 24'h0};
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Expected {wr_en, wr_add, wr_data, busy, done} j cycles after an accepted start.
    function automatic logic [134:0] exp_vec(input int j);
        if (j <= 10) return {1'b1, 4'(j), exp_keys[j], 1'b1, 1'b0};
        if (j == 11) return {1'b0, 4'd10, exp_keys[10], 1'b0, 1'b1};
        return {1'b0, 4'd10, exp_keys[10], 1'b0, 1'b0};
    endfunction

    // Drive a start (held for 'hold' edges), optionally swap key_in after cycle chg_at,
    // and record outputs for ncyc cycles.
    task automatic capture(input logic [127:0] key, input int hold, input int ncyc,
                           input int chg_at, input logic [127:0] chg_key);
        @(negedge clock);
        key_in = key;
        start  = 1'b1;
        @(posedge clock);
        for (int c = 0; c < ncyc; c++) begin
            #1;
            obs_en[c]   = wr_en;
            obs_add[c]  = wr_add;
            obs_data[c] = wr_data;
            obs_busy[c] = busy;
            obs_done[c] = done;
            if (c >= hold - 1) start = 1'b0;
            if (c == chg_at) key_in = chg_key;
            @(posedge clock);
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        key_in  = '0;
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({wr_en, wr_add, wr_data, busy, done} !== 135'h0) begin
            errors++;
            $display("FAIL reset_outputs got en=%b add=%0d data=%h busy=%b done=%b want all zero",
                     wr_en, wr_add, wr_data, busy, done);
        end
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({wr_en, busy, done, sub_in} !== 35'h0) begin
            errors++;
            $display("FAIL reset_idle got en=%b busy=%b done=%b sub_in=%h want 0 0 0 00000000",
                     wr_en, busy, done, sub_in);
        end
    endtask

    task automatic test_fips();
        logic [127:0] key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ref_expand(key);
        capture(key, 1, 13, -1, '0);
        for (int c = 0; c < 13; c++) begin
            checks++;
            if ({obs_en[c], obs_add[c], obs_data[c], obs_busy[c], obs_done[c]} !== exp_vec(c)) begin
                errors++;
                $display("FAIL fips_cycle%0d got %h want %h", c,
                         {obs_en[c], obs_add[c], obs_data[c], obs_busy[c], obs_done[c]}, exp_vec(c));
            end
        end
        checks++;
        if (obs_data[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            errors++;
            $display("FAIL fips_addr1 got %h want a0fafe1788542cb123a339392a6c7605", obs_data[1]);
        end
        checks++;
        if (obs_data[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            errors++;
            $display("FAIL fips_addr10 got %h want d014f9a8c9ee2589e13f0cc8b6630ca6", obs_data[10]);
        end
        $display("fips key %h done_at_cycle11=%b", key, obs_done[11]);
    endtask

    task automatic test_zero_key();
        ref_expand('0);
        capture('0, 1, 13, -1, '0);
        for (int c = 0; c < 13; c++) begin
            checks++;
            if ({obs_en[c], obs_add[c], obs_data[c], obs_busy[c], obs_done[c]} !== exp_vec(c)) begin
                errors++;
                $display("FAIL zero_cycle%0d got %h want %h", c,
                         {obs_en[c], obs_add[c], obs_data[c], obs_busy[c], obs_done[c]}, exp_vec(c));
            end
        end
        checks++;
        if (obs_data[1] !== 128'h62636363626363636263636362636363) begin
            errors++;
            $display("FAIL zero_addr1 got %h want 62636363626363636263636362636363", obs_data[1]);
        end
        checks++;
        if (obs_data[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            errors++;
            $display("FAIL zero_addr10 got %h want b4ef5bcb3e92e21123e951cf6f8f188e", obs_data[10]);
        end
        $display("zero key round10 %h", obs_data[10]);
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
            ref_expand(key);
            capture(key, 1, 13, -1, '0);
            for (int c = 0; c < 13; c++) begin
                checks++;
                if ({obs_en[c], obs_add[c], obs_data[c], obs_busy[c], obs_done[c]} !== exp_vec(c)) begin
                    errors++;
                    $display("FAIL random%0d_cycle%0d got %h want %h", n, c,
                             {obs_en[c], obs_add[c], obs_data[c], obs_busy[c], obs_done[c]}, exp_vec(c));
                end
            end
            $display("random key %h round10 %h", key, obs_data[10]);
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
        int writes = 0;
        ref_expand(key);
        // Start held 20 edges: second expansion starts 13 cycles after the first.
        capture(key, 20, 30, -1, '0);
        for (int c = 0; c < 30; c++) begin
            int j = (c < 13) ? c : c - 13;
            if (obs_en[c]) writes++;
            checks++;
            if ({obs_en[c], obs_add[c], obs_data[c], obs_busy[c], obs_done[c]} !== exp_vec(j)) begin
                errors++;
                $display("FAIL b2b_cycle%0d got %h want %h", c,
                         {obs_en[c], obs_add[c], obs_data[c], obs_busy[c], obs_done[c]}, exp_vec(j));
            end
        end
        checks++;
        if (writes != 22) begin
            errors++;
            $display("FAIL b2b_write_count got %0d want 22", writes);
        end
        $display("back-to-back key %h writes %0d", key, writes);
    endtask

    task automatic test_key_change();
        logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] other = ~key;
        ref_expand(key);
        capture(key, 1, 13, 2, other);
        for (int c = 0; c < 13; c++) begin
            checks++;
            if ({obs_en[c], obs_add[c], obs_data[c], obs_busy[c], obs_done[c]} !== exp_vec(c)) begin
                errors++;
                $display("FAIL keychg_cycle%0d got %h want %h", c,
                         {obs_en[c], obs_add[c], obs_data[c], obs_busy[c], obs_done[c]}, exp_vec(c));
            end
        end
        $display("key change ignored, key %h round10 %h", key, obs_data[10]);
    endtask

    task automatic test_reset_mid();
        logic [127:0] key = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
        key_in = key;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({wr_en, busy, done, wr_add, wr_data} !== 135'h0) begin
            errors++;
            $display("FAIL midreset_async got en=%b busy=%b done=%b add=%0d data=%h want all zero",
                     wr_en, busy, done, wr_add, wr_data);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clock);
            #1;
            checks++;
            if ({wr_en, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL midreset_hold%0d got en=%b busy=%b done=%b want 0 0 0",
                         c, wr_en, busy, done);
            end
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({wr_en, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_release got en=%b busy=%b done=%b want 0 0 0", wr_en, busy, done);
        end
        key = {$urandom, $urandom, $urandom, $urandom};
        ref_expand(key);
        capture(key, 1, 13, -1, '0);
        for (int c = 0; c < 13; c++) begin
            checks++;
            if ({obs_en[c], obs_add[c], obs_data[c], obs_busy[c], obs_done[c]} !== exp_vec(c)) begin
                errors++;
                $display("FAIL postreset_cycle%0d got %h want %h", c,
                         {obs_en[c], obs_add[c], obs_data[c], obs_busy[c], obs_done[c]}, exp_vec(c));
            end
        end
        $display("mid-run reset then clean run, key %h round10 %h", key, obs_data[10]);
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        key_in  = '0;
        build_sbox();
        test_reset();
        test_fips();
        test_zero_key();
        test_random();
        test_back_to_back();
        test_key_change();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
